// File: rtl/sf_status_ascii_formatter.sv
// Converts a tester status snapshot (pattern, address, mode, error count) into fixed-width
// ASCII lines for a 2x16 LCD and a 35-character UART line, using a serial double-dabble.
module sf_status_ascii_formatter #(
    parameter int unsigned PARM_ERR_WIDTH    = 24,
    parameter int unsigned PARM_ERR_DIGITS   = 8,
    parameter int unsigned PARM_ADDR_NIBBLES = 8
) (
    input  logic                      i_clk_40mhz,
    input  logic                      i_rst_40mhz_n,
    input  logic                      i_update,
    input  logic [31:0]               i_addr_start,
    input  logic [1:0]                i_pattern_sel,
    input  logic                      i_pattern_known,
    input  logic [2:0]                i_mode,
    input  logic [PARM_ERR_WIDTH-1:0] i_error_count,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [127:0]              o_lcd_ascii_line1,
    output logic [127:0]              o_lcd_ascii_line2,
    output logic [279:0]              o_term_ascii_line,
    output logic                      o_term_valid,
    input  logic                      i_term_ready
);

    typedef enum logic [1:0] {StIdle, StConvert, StLoad} state_e;

    localparam int unsigned CntW      = $clog2(PARM_ERR_WIDTH + 1);
    localparam logic [63:0] ErrMax    = 64'(10 ** PARM_ERR_DIGITS) - 64'd1;
    localparam logic [127:0] BlankLine = {16{8'h20}};
    localparam logic [279:0] BlankTerm = {{33{8'h20}}, 8'h0D, 8'h0A};

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [31:0]               bcd_q, bcd_d, bcd_adj;
    logic [PARM_ERR_WIDTH-1:0] bin_q, bin_d;
    logic [31:0]               addr_q, addr_d;
    logic [1:0]                sel_q, sel_d;
    logic                      known_q, known_d;
    logic [2:0]                mode_q, mode_d;
    logic                      sat_q, sat_d;
    logic                      pend_q, pend_d;
    logic                      done_q, done_d;
    logic [127:0]              line1_q, line1_d, line2_q, line2_d;
    logic [279:0]              term_q, term_d;
    logic                      tvalid_q, tvalid_d;
    logic                      tdirty_q, tdirty_d;
    logic                      treload_q, treload_d;
    logic [1:0]                rst_sync_q;
    logic                      start;

    logic [7:0]                pat_char;
    logic [23:0]               mode_txt;
    logic [63:0]               addr_field, cnt_field;
    logic [127:0]              line1_new, line2_new;
    logic [279:0]              term_new, term_reload;
    logic                      handshake;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Double-dabble correction step applied before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 8; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Field bytes are indexed from the right so both fields stay right-aligned.
    always_comb begin
        addr_field = {8{8'h20}};
        cnt_field  = {8{8'h20}};
        for (int i = 0; i < 8; i++) begin
            if (i < int'(PARM_ADDR_NIBBLES)) begin
                addr_field[8*i +: 8] = hex_char(addr_q[4*i +: 4]);
            end
            if (i < int'(PARM_ERR_DIGITS)) begin
                if (sat_q) begin
                    cnt_field[8*i +: 8] = (i == int'(PARM_ERR_DIGITS) - 1) ? 8'h3E : 8'h39;
                end else begin
                    cnt_field[8*i +: 8] = 8'h30 + {4'h0, bcd_q[4*i +: 4]};
                end
            end
        end
    end

    always_comb begin
        pat_char = known_q ? (8'h41 + {6'b0, sel_q}) : 8'h2A;
        unique case (mode_q)
            3'd0:    mode_txt = "GO ";
            3'd1:    mode_txt = "ERS";
            3'd2:    mode_txt = "PRO";
            3'd3:    mode_txt = "TST";
            3'd4:    mode_txt = "END";
            default: mode_txt = "???";
        endcase
        line1_new   = {"SF3 P", pat_char, " h", addr_field};
        line2_new   = {mode_txt, " ERR ", cnt_field};
        term_new    = {line1_new, 8'h20, line2_new, 8'h0D, 8'h0A};
        term_reload = {line1_q, 8'h20, line2_q, 8'h0D, 8'h0A};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        known_d = known_q;
        mode_d  = mode_q;
        sat_d   = sat_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        line1_d = line1_q;
        line2_d = line2_q;
        start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_update && rst_sync_q[1]) start = 1'b1;
            end
            StConvert: begin
                if (i_update) pend_d = 1'b1;
                if (cnt_q != '0) begin
                    bcd_d = {bcd_adj[30:0], bin_q[PARM_ERR_WIDTH-1]};
                    bin_d = bin_q << 1;
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                line1_d = line1_new;
                line2_d = line2_new;
                done_d  = 1'b1;
                if (pend_q || i_update) begin
                    start  = 1'b1;
                    pend_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (start) begin
            state_d = StConvert;
            cnt_d   = CntW'(PARM_ERR_WIDTH);
            bcd_d   = '0;
            bin_d   = i_error_count;
            addr_d  = i_addr_start;
            sel_d   = i_pattern_sel;
            known_d = i_pattern_known;
            mode_d  = i_mode;
            sat_d   = 64'(i_error_count) > ErrMax;
        end
    end

    // The UART line is frozen while offered; a LOAD that cannot land marks it stale.
    always_comb begin
        handshake = tvalid_q & i_term_ready;
        term_d    = term_q;
        tvalid_d  = tvalid_q;
        tdirty_d  = tdirty_q;
        treload_d = 1'b0;
        if (handshake) begin
            tvalid_d = 1'b0;
            if (tdirty_q) begin
                treload_d = 1'b1;
                tdirty_d  = 1'b0;
            end
        end
        if (treload_q) begin
            term_d   = term_reload;
            tvalid_d = 1'b1;
        end
        if (state_q == StLoad) begin
            if (!tvalid_q || handshake) begin
                term_d    = term_new;
                tvalid_d  = 1'b1;
                tdirty_d  = 1'b0;
                treload_d = 1'b0;
            end else begin
                tdirty_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_40mhz or negedge i_rst_40mhz_n) begin
        if (!i_rst_40mhz_n) begin
            rst_sync_q <= 2'b00;
            state_q    <= StIdle;
            cnt_q      <= '0;
            bcd_q      <= '0;
            bin_q      <= '0;
            addr_q     <= '0;
            sel_q      <= '0;
            known_q    <= 1'b0;
            mode_q     <= '0;
            sat_q      <= 1'b0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            line1_q    <= BlankLine;
            line2_q    <= BlankLine;
            term_q     <= BlankTerm;
            tvalid_q   <= 1'b0;
            tdirty_q   <= 1'b0;
            treload_q  <= 1'b0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            known_q    <= known_d;
            mode_q     <= mode_d;
            sat_q      <= sat_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            line1_q    <= line1_d;
            line2_q    <= line2_d;
            term_q     <= term_d;
            tvalid_q   <= tvalid_d;
            tdirty_q   <= tdirty_d;
            treload_q  <= treload_d;
        end
    end

    assign o_busy            = (state_q != StIdle);
    assign o_done            = done_q;
    assign o_lcd_ascii_line1 = line1_q;
    assign o_lcd_ascii_line2 = line2_q;
    assign o_term_ascii_line = term_q;
    assign o_term_valid      = tvalid_q;

endmodule
